// File: rtl/spi_tra_master.sv
// spi_tra_master: serialises one buffered SPI transaction (spi_id, spi_reg,
// data byte; 24 bits, MSB first) in SPI mode 0 to one of NUM_CS devices.
// Optional build macro SPI_MASTER_RX_EN: when defined, the byte returned on
// miso during the data byte is captured into rx_data; when undefined,
// rx_data is tied to zero and miso is ignored.
module spi_tra_master #(
  parameter int CLK_DIV = 4,
  parameter int NUM_CS  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        spi_id,
  input  logic [7:0]        spi_select,
  input  logic [7:0]        spi_reg,
  input  logic [7:0]        data_tra,
  input  logic              miso,
  output logic              sclk,
  output logic              mosi,
  output logic [NUM_CS-1:0] cs_n,
  output logic              busy,
  output logic              done,
  output logic              sel_err,
  output logic [7:0]        rx_data
);

  // A divider below one would stall the phase counter, so clamp it.
  localparam int DIV = (CLK_DIV < 1) ? 1 : CLK_DIV;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [4:0]    BIT_LAST = 5'd23;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CS_SETUP = 3'd1,
    ST_SHIFT    = 3'd2,
    ST_CS_HOLD  = 3'd3,
    ST_DONE     = 3'd4
  } state_e;

  state_e            state_q;
  logic [CW-1:0]     cnt_q;
  logic [4:0]        bit_q;
  // Frame shadow; its MSB drives mosi directly, and shifting it empty after
  // the last bit leaves mosi low for the hold phase.
  logic [23:0]       tx_q;
  logic              sclk_q;
  logic [NUM_CS-1:0] cs_n_q;
  logic              busy_q;
  logic              done_q;
  logic              sel_err_q;

  logic              sel_ok;
  logic              cnt_last;
  logic [NUM_CS-1:0] cs_sel_d;

`ifdef SPI_MASTER_RX_EN
  // Only the last eight samples (the data byte) are ever reported, so the
  // capture register keeps just those.
  logic [7:0]        rx_sh_q;
  logic [7:0]        rx_q;
`else
  logic              unused_miso;
  assign unused_miso = miso;
`endif

  assign sel_ok   = ({1'b0, spi_select} < 9'(NUM_CS));
  assign cnt_last = (cnt_q == CNT_LAST);

  // One-hot active-low chip-select pattern for the requested index.
  always_comb begin
    cs_sel_d = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (spi_select == 8'(i)) begin
        cs_sel_d[i] = 1'b0;
      end else begin
        cs_sel_d[i] = 1'b1;
      end
    end
  end

  // Transaction FSM: phase timing, serial shifting and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_q     <= 5'd0;
      tx_q      <= 24'd0;
      sclk_q    <= 1'b0;
      cs_n_q    <= '1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sel_err_q <= 1'b0;
`ifdef SPI_MASTER_RX_EN
      rx_sh_q   <= 8'd0;
      rx_q      <= 8'd0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            if (sel_ok) begin
              sel_err_q <= 1'b0;
              busy_q    <= 1'b1;
              cs_n_q    <= cs_sel_d;
              tx_q      <= {spi_id, spi_reg, data_tra};
              cnt_q     <= '0;
              bit_q     <= 5'd0;
              state_q   <= ST_CS_SETUP;
            end else begin
              // Bad index: report and finish without touching the bus.
              sel_err_q <= 1'b1;
              done_q    <= 1'b1;
              state_q   <= ST_DONE;
            end
          end
        end

        ST_CS_SETUP: begin
          if (cnt_last) begin
            cnt_q   <= '0;
            state_q <= ST_SHIFT;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        ST_SHIFT: begin
          if (cnt_last) begin
            cnt_q <= '0;
            if (!sclk_q) begin
              sclk_q <= 1'b1;
`ifdef SPI_MASTER_RX_EN
              rx_sh_q <= {rx_sh_q[6:0], miso};
`endif
            end else begin
              sclk_q <= 1'b0;
              tx_q   <= {tx_q[22:0], 1'b0};
              if (bit_q == BIT_LAST) begin
                bit_q   <= 5'd0;
                state_q <= ST_CS_HOLD;
              end else begin
                bit_q <= bit_q + 5'd1;
              end
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        ST_CS_HOLD: begin
          if (cnt_last) begin
            cnt_q   <= '0;
            cs_n_q  <= '1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
`ifdef SPI_MASTER_RX_EN
            rx_q    <= rx_sh_q;
`endif
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        ST_DONE: begin
          done_q  <= 1'b0;
          cnt_q   <= '0;
          state_q <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
          bit_q   <= 5'd0;
          tx_q    <= 24'd0;
          sclk_q  <= 1'b0;
          cs_n_q  <= '1;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign sclk    = sclk_q;
  assign mosi    = tx_q[23];
  assign cs_n    = cs_n_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign sel_err = sel_err_q;
`ifdef SPI_MASTER_RX_EN
  assign rx_data = rx_q;
`else
  assign rx_data = 8'h00;
`endif

endmodule

// File: tb/tb_spi_tra_master.sv
// Bench for spi_tra_master: two instances (CLK_DIV=4/NUM_CS=8 and
// CLK_DIV=1/NUM_CS=1), a bus monitor with a MISO device model, and
// per-scenario tasks checked against expectations computed from the
// frame timing rules (edge 0 = start edge, SCLK period 2*DIV, done at 50*DIV).
module tb_spi_tra_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       start_a, miso_a, sclk_a, mosi_a, busy_a, done_a, se_a;
  logic [7:0] id_a, sel_a, reg_a, dat_a, rx_a, cs_n_a;
  logic       start_b, miso_b, sclk_b, mosi_b, busy_b, done_b, se_b;
  logic [7:0] id_b, sel_b, reg_b, dat_b, rx_b;
  logic [0:0] cs_n_b;

  spi_tra_master #(.CLK_DIV(4), .NUM_CS(8)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .spi_id(id_a), .spi_select(sel_a),
    .spi_reg(reg_a), .data_tra(dat_a), .miso(miso_a), .sclk(sclk_a), .mosi(mosi_a),
    .cs_n(cs_n_a), .busy(busy_a), .done(done_a), .sel_err(se_a), .rx_data(rx_a));

  spi_tra_master #(.CLK_DIV(1), .NUM_CS(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .spi_id(id_b), .spi_select(sel_b),
    .spi_reg(reg_b), .data_tra(dat_b), .miso(miso_b), .sclk(sclk_b), .mosi(mosi_b),
    .cs_n(cs_n_b), .busy(busy_b), .done(done_b), .sel_err(se_b), .rx_data(rx_b));

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Monitor state, index 0 = dut_a, 1 = dut_b.
  int         nrise [2];
  bit         mbits [2][64];
  int         rise_e[2][64];
  int         last_fall[2];
  int         ndone [2];
  int         done_e[2][4];
  logic [7:0] done_rx[2][4];
  logic       done_se[2][4];
  int         cs_first[2];
  int         cs_last[2];
  int         busy_hi[2];
  logic       prev_s[2];
  int         cs_bad;
  logic [7:0] exp_cs;
  logic [23:0] resp_a, resp_b;
  logic [7:0] rx_model_a;

  task automatic clear_mon(input int id);
    nrise[id] = 0; ndone[id] = 0; last_fall[id] = -1;
    cs_first[id] = -1; cs_last[id] = -1; busy_hi[id] = 0;
    if (id == 0) cs_bad = 0;
  endtask

  task automatic mon(input int id, input logic s, input logic m, input logic d,
                     input logic csl, input logic b, input logic [7:0] rx, input logic se);
    if (s && !prev_s[id]) begin
      if (nrise[id] < 64) begin
        mbits[id][nrise[id]]  = m;
        rise_e[id][nrise[id]] = cyc;
      end
      nrise[id]++;
    end
    if (!s && prev_s[id]) last_fall[id] = cyc;
    prev_s[id] = s;
    if (d) begin
      if (ndone[id] < 4) begin
        done_e[id][ndone[id]]  = cyc;
        done_rx[id][ndone[id]] = rx;
        done_se[id][ndone[id]] = se;
      end
      ndone[id]++;
    end
    if (csl) begin
      if (cs_first[id] < 0) cs_first[id] = cyc;
      cs_last[id] = cyc;
    end
    if (b) busy_hi[id]++;
  endtask

  // Samples 1 time unit after each rising edge; cyc is the index of that edge.
  // The device model presents the response bit for the next SCLK rise.
  task automatic monitor_loop();
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      mon(0, sclk_a, mosi_a, done_a, cs_n_a !== 8'hFF, busy_a, rx_a, se_a);
      if (cs_n_a !== 8'hFF && cs_n_a !== exp_cs) cs_bad++;
      mon(1, sclk_b, mosi_b, done_b, cs_n_b !== 1'b1, busy_b, rx_b, se_b);
      miso_a = (nrise[0] < 24) ? resp_a[23 - nrise[0]] : 1'b0;
      miso_b = resp_b[23 - (nrise[1] % 24)];
    end
  endtask

  task automatic test_reset(input string tag);
    checks++; if (sclk_a !== 1'b0) begin errors++; $display("FAIL %s sclk got=%b exp=0", tag, sclk_a); end
    checks++; if (mosi_a !== 1'b0) begin errors++; $display("FAIL %s mosi got=%b exp=0", tag, mosi_a); end
    checks++; if (cs_n_a !== 8'hFF) begin errors++; $display("FAIL %s cs_n got=%h exp=ff", tag, cs_n_a); end
    checks++; if ({busy_a, done_a, se_a} !== 3'b000) begin errors++; $display("FAIL %s busy/done/sel_err got=%b exp=000", tag, {busy_a, done_a, se_a}); end
    checks++; if (rx_a !== 8'h00) begin errors++; $display("FAIL %s rx_data got=%h exp=00", tag, rx_a); end
    checks++; if ({sclk_b, cs_n_b, busy_b, done_b} !== 4'b0100) begin errors++; $display("FAIL %s dut_b idle got=%b exp=0100", tag, {sclk_b, cs_n_b, busy_b, done_b}); end
  endtask

  // Run one request on dut_a; inj > 0 fires an extra start at edge e0+inj.
  task automatic run_frame_a(input logic [7:0] id, input logic [7:0] sel, input logic [7:0] rg,
                             input logic [7:0] dt, input logic [23:0] resp, input int inj, input string tag);
    int e0; int bad; logic [23:0] frame; logic ok;
    frame = {id, rg, dt};
    ok = (sel < 8'd8);
    exp_cs = ok ? ~(8'h01 << sel[2:0]) : 8'hFF;
    resp_a = resp;
    if (ok) begin
`ifdef SPI_MASTER_RX_EN
      rx_model_a = resp[7:0];
`else
      rx_model_a = 8'h00;
`endif
    end
    @(negedge clk);
    clear_mon(0);
    start_a = 1'b1; id_a = id; sel_a = sel; reg_a = rg; dat_a = dt;
    @(negedge clk);
    start_a = 1'b0;
    id_a = 8'($urandom); reg_a = 8'($urandom); dat_a = 8'($urandom); sel_a = 8'($urandom_range(0, 7));
    e0 = cyc;
    checks++; if (busy_a !== ok) begin errors++; $display("FAIL %s busy_after_start got=%b exp=%b", tag, busy_a, ok); end
    checks++; if (se_a !== !ok) begin errors++; $display("FAIL %s sel_err_after_start got=%b exp=%b", tag, se_a, !ok); end
    for (int c = 0; c < 215; c++) begin
      if (inj > 0 && cyc == e0 + inj - 1) begin
        start_a = 1'b1; id_a = 8'($urandom); reg_a = 8'($urandom); dat_a = 8'($urandom);
      end else begin
        start_a = 1'b0;
      end
      @(negedge clk);
    end
    checks++; if (ndone[0] !== 1) begin errors++; $display("FAIL %s done_count got=%0d exp=1", tag, ndone[0]); end
    checks++; if (done_e[0][0] !== (ok ? e0 + 200 : e0)) begin errors++; $display("FAIL %s done_edge got=%0d exp=%0d", tag, done_e[0][0] - e0, ok ? 200 : 0); end
    checks++; if (done_se[0][0] !== !ok) begin errors++; $display("FAIL %s sel_err_at_done got=%b exp=%b", tag, done_se[0][0], !ok); end
    checks++; if (done_rx[0][0] !== rx_model_a) begin errors++; $display("FAIL %s rx_data got=%h exp=%h", tag, done_rx[0][0], rx_model_a); end
    if (ok) begin
      bad = 0;
      for (int k = 0; k < 24; k++) if (mbits[0][k] !== frame[23 - k] || rise_e[0][k] !== e0 + 8 + 8 * k) bad++;
      checks++; if (nrise[0] !== 24 || bad != 0) begin errors++; $display("FAIL %s mosi_stream rises got=%0d exp=24 bad_bits=%0d frame=%h", tag, nrise[0], bad, frame); end
      checks++; if (last_fall[0] !== e0 + 196) begin errors++; $display("FAIL %s last_fall got=%0d exp=196", tag, last_fall[0] - e0); end
      checks++; if (cs_first[0] !== e0 || cs_last[0] !== e0 + 199 || cs_bad != 0) begin errors++; $display("FAIL %s cs_window got=%0d..%0d bad=%0d exp=0..199 mask=%h", tag, cs_first[0] - e0, cs_last[0] - e0, cs_bad, exp_cs); end
    end else begin
      checks++; if (nrise[0] !== 0 || cs_first[0] !== -1 || busy_hi[0] !== 0) begin errors++; $display("FAIL %s bus_untouched rises=%0d cs_first=%0d busy=%0d exp=0,-1,0", tag, nrise[0], cs_first[0], busy_hi[0]); end
    end
    checks++; if (busy_a !== 1'b0 || se_a !== !ok) begin errors++; $display("FAIL %s end_state busy=%b sel_err=%b exp=0,%b", tag, busy_a, se_a, !ok); end
  endtask

  task automatic test_reset_midframe();
    int e0;
    resp_a = 24'($urandom);
    exp_cs = 8'hDF;
    @(negedge clk);
    clear_mon(0);
    start_a = 1'b1; id_a = 8'($urandom); sel_a = 8'd5; reg_a = 8'($urandom); dat_a = 8'($urandom);
    @(negedge clk);
    start_a = 1'b0;
    e0 = cyc;
    for (int c = 0; c < 120 && cyc < e0 + 99; c++) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (cs_n_a !== 8'hFF || sclk_a !== 1'b0 || busy_a !== 1'b0 || done_a !== 1'b0) begin errors++; $display("FAIL rst_mid immediate cs_n=%h sclk=%b busy=%b done=%b exp=ff,0,0,0", cs_n_a, sclk_a, busy_a, done_a); end
    rx_model_a = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    checks++; if (ndone[0] !== 0) begin errors++; $display("FAIL rst_mid no_done got=%0d exp=0", ndone[0]); end
    checks++; if (cs_first[0] !== e0) begin errors++; $display("FAIL rst_mid cs_started got=%0d exp=0", cs_first[0] - e0); end
  endtask

  task automatic test_back_to_back();
    int e0; int bad; logic [23:0] f1, f2; logic [7:0] exp_rx;
    f1 = 24'($urandom); f2 = 24'($urandom); resp_b = 24'($urandom);
`ifdef SPI_MASTER_RX_EN
    exp_rx = resp_b[7:0];
`else
    exp_rx = 8'h00;
`endif
    @(negedge clk);
    clear_mon(1);
    start_b = 1'b1; id_b = f1[23:16]; reg_b = f1[15:8]; dat_b = f1[7:0]; sel_b = 8'd0;
    @(negedge clk);
    start_b = 1'b0; id_b = 8'($urandom);
    e0 = cyc;
    checks++; if (cs_n_b !== 1'b0 || busy_b !== 1'b1) begin errors++; $display("FAIL b2b first_accept cs_n=%b busy=%b exp=0,1", cs_n_b, busy_b); end
    for (int c = 0; c < 140; c++) begin
      if (cyc == e0 + 50 || cyc == e0 + 51) begin
        start_b = 1'b1; id_b = f2[23:16]; reg_b = f2[15:8]; dat_b = f2[7:0];
      end else begin
        start_b = 1'b0;
      end
      @(negedge clk);
    end
    checks++; if (ndone[1] !== 2) begin errors++; $display("FAIL b2b done_count got=%0d exp=2", ndone[1]); end
    checks++; if (done_e[1][0] !== e0 + 50 || done_e[1][1] !== e0 + 102) begin errors++; $display("FAIL b2b done_edges got=%0d,%0d exp=50,102", done_e[1][0] - e0, done_e[1][1] - e0); end
    bad = 0;
    for (int k = 0; k < 24; k++) begin
      if (mbits[1][k] !== f1[23 - k] || rise_e[1][k] !== e0 + 2 + 2 * k) bad++;
      if (mbits[1][k + 24] !== f2[23 - k] || rise_e[1][k + 24] !== e0 + 54 + 2 * k) bad++;
    end
    checks++; if (nrise[1] !== 48 || bad != 0) begin errors++; $display("FAIL b2b streams rises=%0d exp=48 bad=%0d f1=%h f2=%h", nrise[1], bad, f1, f2); end
    checks++; if (last_fall[1] !== e0 + 101) begin errors++; $display("FAIL b2b last_fall got=%0d exp=101", last_fall[1] - e0); end
    checks++; if (done_rx[1][0] !== exp_rx || done_rx[1][1] !== exp_rx) begin errors++; $display("FAIL b2b rx_data got=%h,%h exp=%h", done_rx[1][0], done_rx[1][1], exp_rx); end
    checks++; if (busy_b !== 1'b0 || cs_n_b !== 1'b1) begin errors++; $display("FAIL b2b end busy=%b cs_n=%b exp=0,1", busy_b, cs_n_b); end
  endtask

  initial begin
    rst = 1'b0;
    start_a = 1'b0; id_a = 8'h00; sel_a = 8'h00; reg_a = 8'h00; dat_a = 8'h00;
    start_b = 1'b0; id_b = 8'h00; sel_b = 8'h00; reg_b = 8'h00; dat_b = 8'h00;
    miso_a = 1'b0; miso_b = 1'b0; resp_a = 24'd0; resp_b = 24'd0;
    exp_cs = 8'hFF; rx_model_a = 8'h00; prev_s[0] = 1'b0; prev_s[1] = 1'b0;
    clear_mon(0); clear_mon(1);
    fork
      monitor_loop();
    join_none
    repeat (3) @(negedge clk);
    test_reset("reset_held");
    rst = 1'b1;
    repeat (2) @(negedge clk);
    test_reset("reset_released");

    run_frame_a(8'hA5, 8'd3, 8'h12, 8'h3C, {16'($urandom), 8'hC3}, 0, "write_frame");
    for (int i = 0; i < 3; i++)
      run_frame_a(8'($urandom), 8'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 24'($urandom), 0, "rand_frame");
    run_frame_a(8'($urandom), 8'd8, 8'($urandom), 8'($urandom), 24'($urandom), 0, "sel_err_8");
    run_frame_a(8'($urandom), 8'($urandom_range(9, 255)), 8'($urandom), 8'($urandom), 24'($urandom), 0, "sel_err_rand");
    run_frame_a(8'($urandom), 8'd7, 8'($urandom), 8'($urandom), 24'($urandom), 0, "sel_err_clear");
    run_frame_a(8'hA5, 8'd3, 8'h12, 8'h3C, 24'($urandom), 50, "start_busy");
    run_frame_a(8'($urandom), 8'd0, 8'($urandom), 8'($urandom), 24'($urandom), 201, "start_in_done");
    test_reset_midframe();
    run_frame_a(8'($urandom), 8'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 24'($urandom), 0, "after_reset");
    test_back_to_back();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_tra_master.md
Name: spi_tra_master

Overview:
- Serialises one buffered SPI transaction: spi_id byte, then spi_reg byte, then data byte.
- Sits directly downstream of the transmit buffer that splits the 32-bit SCB/Object-Dictionary word into spi_id, spi_select, spi_reg and data bytes.
- Drives SCLK/MOSI/CS_n to the selected front-end device in SPI mode 0 and returns the byte read back on MISO during the data phase.

Parameters:
- CLK_DIV, 4: SCLK half-period in clk cycles. Values below 1 behave as 1.
- NUM_CS, 8: number of chip-select lines, range 1..256.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle request; buffer outputs valid in the same cycle
- spi_id  in  8  first byte shifted out (device/command id)
- spi_select  in  8  chip-select index
- spi_reg  in  8  second byte shifted out (register address)
- data_tra  in  8  third byte shifted out (write data)
- miso  in  1  serial data from device
- sclk  out  1  SPI clock, idle low
- mosi  out  1  serial data to device
- cs_n  out  NUM_CS  active-low chip selects
- busy  out  1  transaction in progress
- done  out  1  one-cycle completion pulse
- sel_err  out  1  last request had spi_select >= NUM_CS
- rx_data  out  8  byte sampled on MISO during the data byte

Behaviour:
- Reset (asynchronous, active-low):
  - sclk=0, mosi=0, cs_n all 1, busy=0, done=0, sel_err=0, rx_data=0, FSM=IDLE.
  - Reset mid-frame releases cs_n at once and produces no done.
- FSM states: IDLE, CS_SETUP, SHIFT, CS_HOLD, DONE.
- IDLE:
  - On start=1, latch all four input bytes into shadow registers at that edge (edge 0).
  - Frame = {spi_id, spi_reg, data_tra}, 24 bits, MSB first.
  - If spi_select >= NUM_CS: go to DONE with sel_err=1. cs_n, sclk and mosi are not touched.
  - Otherwise: sel_err=0, busy=1, cs_n[spi_select]=0, mosi=frame[23], go to CS_SETUP.
- CS_SETUP: CLK_DIV cycles with sclk=0, then SHIFT.
- SHIFT: 24 bits. For each bit:
  - Low phase: CLK_DIV cycles, sclk=0, mosi stable.
  - High phase: CLK_DIV cycles, sclk=1.
  - miso is sampled at the edge that raises sclk.
  - mosi advances to the next bit at the edge that lowers sclk.
  - After the 24th high phase, sclk=0, mosi=0, go to CS_HOLD.
- SCLK edge timing: first rising edge at edge 2*CLK_DIV; last falling edge at edge 49*CLK_DIV.
- CS_HOLD: CLK_DIV cycles with sclk=0 and cs_n still asserted, then go to DONE.
- DONE (single cycle):
  - At the entry edge (50*CLK_DIV): cs_n all 1, busy=0, done=1, rx_data updated.
  - Next cycle: IDLE, done=0.
  - For CLK_DIV=4, done is high for the cycle following edge 200.
- Back-to-back: start is accepted again in the cycle after done.
- start while busy=1, or in the DONE cycle, is ignored. No queueing.
- sel_err holds until the next accepted start.
- miso is assumed synchronous to the sclk timing; no extra synchroniser latency is added.

Optional Feature:
- Macro SPI_MASTER_RX_EN.
- Defined:
  - miso is shifted into a 24-bit register on each sclk rising edge.
  - rx_data is loaded with bits [7:0] (the samples taken during the data byte) in DONE.
  - On a sel_err request, rx_data keeps its previous value.
- Undefined:
  - No capture logic.
  - rx_data is constant 0 and miso is unused.
  - All other timing is identical.

Test Plan:
- Write frame, CLK_DIV=4, NUM_CS=8. Input: spi_id=0xA5, spi_select=3, spi_reg=0x12, data_tra=0x3C, start pulse. Expected:
  - cs_n=8'b1111_0111 from edge 0 to edge 200.
  - MOSI bitstream 0xA5123C captured on 24 sclk rising edges.
  - done at edge 200; busy low after.
- Readback (SPI_MASTER_RX_EN): the device model drives 0xC3 on miso during the data byte. Expected: rx_data=0xC3 when done pulses. With the macro undefined, rx_data=0x00.
- Invalid select: spi_select=8, start pulse. Expected:
  - done and sel_err=1 one cycle after start.
  - cs_n stays 0xFF and sclk stays 0 throughout.
  - The next valid request clears sel_err.
- Start during busy: second start at edge 50 with different bytes. Expected: ignored; the frame stays 0xA5123C and exactly one done pulse occurs.
- Reset mid-frame: assert rst=0 at edge 100. Expected:
  - cs_n=0xFF, sclk=0, busy=0 immediately, no done.
  - After release, a fresh request completes normally.
- CLK_DIV=1, NUM_CS=1, spi_select=0, back-to-back starts. Expected:
  - Each frame takes 50 cycles.
  - 24 sclk periods of 2 cycles each.
  - The second start is accepted the cycle after the first done.
